qoi_stream_encoder: RTL

// - Parametrised streaming QOI encoder: valid/ready pixel stream in, valid/ready encoded-byte stream out, one clock domain.
// - Successor to the SPI-polled encoder; the byte buffer absorbs multi-byte ops (run + RGBA = 6 bytes) under backpressure.
// - Sits between the camera/pixel FIFO and the MCU byte link; emits QOI op stream only (no 14-byte file header).

---
 rtl/qoi_stream_encoder.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/qoi_stream_encoder.sv
`default_nettype none
// ============================================================================
//  Module  : qoi_stream_encoder
//  Brief   : Streaming QOI op encoder. It takes a valid/ready pixel stream and
//            produces a valid/ready encoded byte stream. It emits no file
//            header. A 6-byte queue holds the worst case of a pending run
//            byte followed by an RGBA op.
//  Option  : QOI_END_MARKER_EN - when defined, the 8-byte QOI end marker
//            (00 x7, 01) is appended after the last op of each image.
//  Rev     : 1.0  initial release
// ============================================================================
module qoi_stream_encoder #(
  parameter int CHANNELS = 4,
  parameter int RUN_MAX  = 62,
  parameter int IDX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [CHANNELS*8-1:0] pix_data,
  input  logic                  pix_last,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic [7:0]            byte_data,
  output logic                  byte_last,
  output logic                  done
);

  localparam logic [2:0] c_CLEAR    = 3'd0;
  localparam logic [2:0] c_IDLE     = 3'd1;
  localparam logic [2:0] c_CLASSIFY = 3'd2;
  localparam logic [2:0] c_EMIT     = 3'd3;
  localparam logic [2:0] c_FIN      = 3'd4;
`ifdef QOI_END_MARKER_EN
  localparam logic [2:0] c_ENDMK    = 3'd5;
`endif

  logic [2:0]  r_state;
  logic [31:0] r_pix;        // current pixel, always RGBA
  logic        r_last;
  logic [31:0] r_prev;
  logic [5:0]  r_run;
  logic [31:0] r_idx [0:(1<<IDX_BITS)-1];
  logic [7:0]  r_q   [0:5];
  logic [2:0]  r_cnt;
`ifdef QOI_END_MARKER_EN
  logic [2:0]  r_mk;
`endif

  logic [31:0]         w_in;
  logic [IDX_BITS-1:0] w_hash;
  logic                w_same, w_idx_hit, w_run_flush, w_fire;
  logic [5:0]          w_run_inc;
  logic signed [7:0]   w_dr, w_dg, w_db;
  logic signed [8:0]   w_drg, w_dbg;
  logic                w_diff_ok, w_luma_ok, w_a_eq;
  logic [7:0]          w_op [0:4];
  logic [2:0]          w_opn;
  logic [7:0]          w_qb [0:5];
  logic [2:0]          w_qn;

  // RGB input gets an opaque alpha so the rest of the datapath is always RGBA.
  generate
    if (CHANNELS == 3) begin : g_rgb
      assign w_in = {pix_data, 8'hFF};
    end else begin : g_rgba
      assign w_in = pix_data[31:0];
    end
  endgenerate

  assign w_hash = IDX_BITS'(13'd3  * {5'd0, r_pix[31:24]} + 13'd5  * {5'd0, r_pix[23:16]}
                          + 13'd7  * {5'd0, r_pix[15:8]}  + 13'd11 * {5'd0, r_pix[7:0]});

  assign w_same      = (r_pix == r_prev);
  assign w_idx_hit   = (r_idx[w_hash] == r_pix);
  assign w_run_inc   = r_run + 6'd1;
  assign w_run_flush = (w_run_inc == 6'(RUN_MAX)) || r_last;
  assign w_fire      = byte_valid && byte_ready;

  // Channel deltas wrap in 8 bits. Luma differences need the 9th bit.
  assign w_dr  = r_pix[31:24] - r_prev[31:24];
  assign w_dg  = r_pix[23:16] - r_prev[23:16];
  assign w_db  = r_pix[15:8]  - r_prev[15:8];
  assign w_drg = {w_dr[7], w_dr} - {w_dg[7], w_dg};
  assign w_dbg = {w_db[7], w_db} - {w_dg[7], w_dg};
  assign w_a_eq    = (r_pix[7:0] == r_prev[7:0]);
  assign w_diff_ok = w_a_eq && (w_dr >= -8'sd2) && (w_dr <= 8'sd1)
                            && (w_dg >= -8'sd2) && (w_dg <= 8'sd1)
                            && (w_db >= -8'sd2) && (w_db <= 8'sd1);
  assign w_luma_ok = w_a_eq && (w_dg >= -8'sd32) && (w_dg <= 8'sd31)
                            && (w_drg >= -9'sd8) && (w_drg <= 9'sd7)
                            && (w_dbg >= -9'sd8) && (w_dbg <= 9'sd7);

  // Pick the op for a non-run pixel by priority INDEX > DIFF > LUMA > RGB > RGBA.
  always_comb begin
    for (int i = 0; i < 5; i++) w_op[i] = 8'h00;
    w_opn = 3'd0;
    if (w_idx_hit) begin
      w_op[0] = {2'b00, 6'(w_hash)};
      w_opn   = 3'd1;
    end else if (w_diff_ok) begin
      w_op[0] = {2'b01, w_dr[1:0] + 2'd2, w_dg[1:0] + 2'd2, w_db[1:0] + 2'd2};
      w_opn   = 3'd1;
    end else if (w_luma_ok) begin
      w_op[0] = {2'b10, w_dg[5:0] + 6'd32};
      w_op[1] = {w_drg[3:0] + 4'd8, w_dbg[3:0] + 4'd8};
      w_opn   = 3'd2;
    end else if (w_a_eq) begin
      w_op[0] = 8'hFE;
      w_op[1] = r_pix[31:24];
      w_op[2] = r_pix[23:16];
      w_op[3] = r_pix[15:8];
      w_opn   = 3'd4;
    end else begin
      w_op[0] = 8'hFF;
      w_op[1] = r_pix[31:24];
      w_op[2] = r_pix[23:16];
      w_op[3] = r_pix[15:8];
      w_op[4] = r_pix[7:0];
      w_opn   = 3'd5;
    end
  end

  // Build the queue load. A run byte is placed ahead of the op when one is pending.
  always_comb begin
    for (int i = 0; i < 6; i++) w_qb[i] = 8'h00;
    w_qn = 3'd0;
    if (w_same) begin
      if (w_run_flush) begin
        w_qb[0] = {2'b11, r_run};            // (run+1)-1
        w_qn    = 3'd1;
      end
    end else if (r_run != 6'd0) begin
      w_qb[0] = {2'b11, r_run - 6'd1};
      for (int i = 0; i < 5; i++) w_qb[i+1] = w_op[i];
      w_qn = w_opn + 3'd1;
    end else begin
      for (int i = 0; i < 5; i++) w_qb[i] = w_op[i];
      w_qn = w_opn;
    end
  end

  // Main FSM, encoder state and byte queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_CLEAR;
      r_pix   <= 32'h0;
      r_last  <= 1'b0;
      r_prev  <= 32'h000000FF;
      r_run   <= 6'd0;
      r_cnt   <= 3'd0;
      for (int i = 0; i < 6; i++) r_q[i] <= 8'h00;
      for (int i = 0; i < (1<<IDX_BITS); i++) r_idx[i] <= 32'h0;
`ifdef QOI_END_MARKER_EN
      r_mk    <= 3'd0;
`endif
    end else begin
      case (r_state)
        c_CLEAR: begin
          for (int i = 0; i < (1<<IDX_BITS); i++) r_idx[i] <= 32'h0;
          r_prev  <= 32'h000000FF;
          r_run   <= 6'd0;
          r_cnt   <= 3'd0;
          r_state <= c_IDLE;
        end
        c_IDLE: begin
          if (pix_valid) begin
            r_pix   <= w_in;
            r_last  <= pix_last;
            r_state <= c_CLASSIFY;
          end
        end
        c_CLASSIFY: begin
          r_prev <= r_pix;
          if (w_same) begin
            r_run <= w_run_flush ? 6'd0 : w_run_inc;
          end else begin
            r_run          <= 6'd0;
            r_idx[w_hash]  <= r_pix;
          end
          for (int i = 0; i < 6; i++) r_q[i] <= w_qb[i];
          r_cnt   <= w_qn;
          r_state <= (w_qn != 3'd0) ? c_EMIT : c_IDLE;
        end
        c_EMIT: begin
          if (w_fire) begin
            for (int i = 0; i < 5; i++) r_q[i] <= r_q[i+1];
            r_q[5] <= 8'h00;
            r_cnt  <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
`ifdef QOI_END_MARKER_EN
              r_mk    <= 3'd0;
              r_state <= r_last ? c_ENDMK : c_IDLE;
`else
              r_state <= r_last ? c_FIN : c_IDLE;
`endif
            end
          end
        end
`ifdef QOI_END_MARKER_EN
        c_ENDMK: begin
          if (w_fire) begin
            r_mk <= r_mk + 3'd1;
            if (r_mk == 3'd7) r_state <= c_FIN;
          end
        end
`endif
        c_FIN:   r_state <= c_CLEAR;
        default: r_state <= c_CLEAR;
      endcase
    end
  end

  assign pix_ready = (r_state == c_IDLE);
  assign done      = (r_state == c_FIN);

  // Byte output mux. The head of the queue is shown while in EMIT, and the marker byte while in ENDMK.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_last  = 1'b0;
    if (r_state == c_EMIT) begin
      byte_valid = 1'b1;
      byte_data  = r_q[0];
`ifndef QOI_END_MARKER_EN
      byte_last  = r_last && (r_cnt == 3'd1);
`endif
    end
`ifdef QOI_END_MARKER_EN
    else if (r_state == c_ENDMK) begin
      byte_valid = 1'b1;
      byte_data  = (r_mk == 3'd7) ? 8'h01 : 8'h00;
      byte_last  = (r_mk == 3'd7);
    end
`endif
  end

endmodule
`default_nettype wire
